instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding request to instruction memory,
// holds the fetched word until downstream accepts it, supports redirect (flush)
// and misaligned-PC faults.
// Optional feature: define FETCH_TIMEOUT_EN to bound the WAIT state with a
// response timeout (TIMEOUT_CYCLES) plus a stale-response filter.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  output logic        instr_fault,
  output logic        pc_advance
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        fault_q, fault_d;
  logic        drop_q, drop_d;
  logic        rsp_valid;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          stale_q, stale_d;
`endif

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_data  = data_q;
  assign instr_addr  = iaddr_q;
  assign instr_fault = fault_q;
  assign pc_advance  = instr_valid & instr_ready & ~flush;

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    iaddr_d = iaddr_q;
    fault_d = fault_q;
    drop_d  = drop_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
    stale_d = stale_q;
    // A response belonging to a timed-out request is swallowed wherever it lands.
    rsp_valid = imem_rvalid & ~stale_q;
    if (imem_rvalid && stale_q) stale_d = 1'b0;
`else
    rsp_valid = imem_rvalid;
`endif

    case (state_q)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          if (pc_addr[1:0] == 2'b00) begin
            addr_d  = pc_addr;
            state_d = S_REQ;
          end else begin
            // Misaligned PC: report a fault without touching memory.
            data_d  = NOP_INSTR;
            fault_d = 1'b1;
            iaddr_d = pc_addr;
            state_d = S_HOLD;
          end
        end
      end

      S_REQ: begin
        // The request stays up until granted even if flushed; drop marks it.
        if (flush) drop_d = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end

      S_WAIT: begin
        if (rsp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = imem_rdata;
            fault_d = 1'b0;
            iaddr_d = addr_q;
            state_d = S_HOLD;
          end
        end else begin
          if (flush) drop_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            stale_d = 1'b1;
            tmo_d   = '0;
            if (drop_q || flush) begin
              drop_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              data_d  = NOP_INSTR;
              fault_d = 1'b1;
              iaddr_d = addr_q;
              state_d = S_HOLD;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end

      S_HOLD: begin
        if (flush || instr_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= NOP_INSTR;
      iaddr_q <= '0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
      stale_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iaddr_q <= iaddr_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
      stale_q <= stale_d;
`endif
    end
  end

endmodule
